uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter in the IO module group.
- Configurable bit period, data width, parity mode and stop-bit count.
- Small internal TX FIFO so the CPU/bus side can queue bytes without waiting for each frame.
- Frames go out back-to-back with no idle gap while the FIFO is non-empty.
- Sits between the memory-mapped IO register block and the UART pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (>= 2).
- DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits (1 or 2).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, >= 2).

Ports:
- i_Clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_Tx_DV  input  1  write strobe; one byte per cycle while high.
- i_Tx_Byte  input  DATA_BITS  data to queue.
- o_Tx_Ready  output  1  FIFO not full; a write is accepted iff i_Tx_DV && o_Tx_Ready.
- o_Tx_Active  output  1  frame in progress (start bit through last stop bit).
- o_Tx_Serial  output  1  serial line, registered, idle high.
- o_Tx_Done  output  1  one-cycle pulse per completed frame.
- o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  entries currently queued.

Behaviour:
- Clock and reset: one clock, i_Clock. reset is synchronous, active-high, and sampled on the i_Clock rising edge.
- Reset values:
  - o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0.
  - o_Fifo_Count = 0, o_Tx_Ready = 1.
  - FSM = IDLE; bit counter and clock counter = 0.
  - FIFO pointers cleared; contents discarded.
- Reset mid-frame: the line returns high on the next edge. The partial frame is abandoned with no o_Tx_Done. All queued bytes are lost.
- FIFO:
  - Push on an edge where i_Tx_DV && o_Tx_Ready.
  - o_Tx_Ready = (count < FIFO_DEPTH), combinational from the registered count.
  - When full, a write is dropped even if a pop occurs on the same edge.
  - Push and pop on the same edge leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: every byte passes through the FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - line = 1.
  - If the FIFO is non-empty: pop the head into the shift register, compute parity, clear counters, go to START. o_Tx_Active goes 1 on that same edge.
- Parity: even = XOR of the data bits; odd = inverted XOR. Computed once at load.
- START: line = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - line = current data bit for CLKS_PER_BIT cycles each, starting at bit 0.
  - After bit DATA_BITS-1: go to PARITY if PARITY != 0, else STOP.
- PARITY: line = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - line = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: assert o_Tx_Done for exactly one cycle (registered, visible the cycle after the stop period ends).
  - If the FIFO is non-empty: pop and go directly to START (o_Tx_Active stays 1, zero idle cycles).
  - Otherwise: o_Tx_Active = 0, go to IDLE.
- Latency: byte written at edge k → o_Tx_Serial falls at edge k+1 if the FSM is IDLE.
- Frame length: exactly (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Clock counter width: $clog2(CLKS_PER_BIT). The counter is compared against CLKS_PER_BIT-1 and never overflows.
- i_Tx_DV is level-qualified per cycle. Holding it high for N cycles queues N bytes (subject to o_Tx_Ready). It need not drop between bytes.
- Unknown FSM encoding → IDLE.

Test Plan:
- 8N1, CLKS_PER_BIT=4: write 0xA5 at edge 0.
  - Line low at edge 1.
  - Data sequence 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high.
  - Frame 40 cycles; one o_Tx_Done pulse; o_Tx_Active high for exactly 40 cycles.
- Parity, 8E1 then 8O1, byte 0xA5:
  - Parity bit 0 (even) and 1 (odd) after data bit 7.
  - Frame 44 cycles.
- 7E2, byte 0x41:
  - Data 1,0,0,0,0,0,1, parity 0, two stop bits.
  - Frame 44 cycles, then line idles high.
- Back-to-back: write 0x11, 0x22, 0x33 on three consecutive cycles (8N1, CLKS_PER_BIT=4).
  - Three contiguous frames over 120 cycles, no idle gap.
  - o_Tx_Active continuously high.
  - Three o_Tx_Done pulses 40 cycles apart.
  - o_Fifo_Count peaks at 2.
- Overflow, FIFO_DEPTH=4: during an active frame, write 5 bytes on consecutive cycles.
  - First 4 accepted; o_Fifo_Count = 4; o_Tx_Ready = 0; 5th byte dropped.
  - Exactly 4 further frames are transmitted.
- Reset mid-frame: assert reset during data bit 3 with 2 bytes queued.
  - Next edge: o_Tx_Serial = 1, o_Tx_Active = 0, o_Fifo_Count = 0.
  - No o_Tx_Done pulse; line stays high afterwards.

Source files
------------

// File: rtl/uart_tx_param.sv
`timescale 1ns/1ps
// Parametrised UART transmitter with a small TX FIFO in front of it.
// Frames (start, DATA_BITS LSB first, optional parity, stop bits) go out back-to-back while bytes are queued.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [PW:0]   DEPTH     = (PW+1)'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]          count_reg;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;

    // Transmit FSM state
    state_t               state_reg, state_next;
    logic [CW-1:0]        clk_cnt_reg, clk_cnt_next;
    logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] data_reg, data_next;
    logic                 parity_reg, parity_next;
    logic                 serial_reg, serial_next;
    logic                 active_reg, active_next;
    logic                 done_reg, done_next;
    logic                 clk_last, load;

    assign o_Tx_Ready = (count_reg < DEPTH);
    assign push       = i_Tx_DV && o_Tx_Ready;
    assign fifo_empty = (count_reg == '0);
    assign head       = fifo_mem[rd_ptr_reg];
    assign clk_last   = (clk_cnt_reg == CLK_LAST);

    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            serial_reg  <= 1'b1;
            active_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            parity_reg  <= parity_next;
            serial_reg  <= serial_next;
            active_reg  <= active_next;
            done_reg    <= done_next;
        end
    end

    // serial_next always carries the line level of the state being entered, so the pin is a clean register
    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_last ? '0 : clk_cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        parity_next  = parity_reg;
        serial_next  = serial_reg;
        active_next  = active_reg;
        done_next    = 1'b0;
        load         = 1'b0;
        pop          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                serial_next  = 1'b1;
                active_next  = 1'b0;
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                load         = !fifo_empty;
            end
            ST_START: begin
                if (clk_last) begin
                    state_next  = ST_DATA;
                    serial_next = data_reg[0];
                end
            end
            ST_DATA: begin
                if (clk_last) begin
                    if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_next = '0;
                        if (PARITY != 0) begin
                            state_next  = ST_PARITY;
                            serial_next = parity_reg;
                        end else begin
                            state_next  = ST_STOP;
                            serial_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        data_next    = data_reg >> 1;
                        serial_next  = data_reg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (clk_last) begin
                    state_next   = ST_STOP;
                    serial_next  = 1'b1;
                    bit_cnt_next = '0;
                end
            end
            ST_STOP: begin
                if (clk_last) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        done_next    = 1'b1;
                        bit_cnt_next = '0;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_next  = ST_IDLE;
                            active_next = 1'b0;
                            serial_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next   = ST_IDLE;
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                serial_next  = 1'b1;
                active_next  = 1'b0;
            end
        endcase
        // Loading a new frame is shared by IDLE and the end of STOP (zero-gap chaining)
        if (load) begin
            pop          = 1'b1;
            data_next    = head;
            parity_next  = (^head) ^ PAR_ODD;
            clk_cnt_next = '0;
            bit_cnt_next = '0;
            state_next   = ST_START;
            serial_next  = 1'b0;
            active_next  = 1'b1;
        end
    end

    assign o_Tx_Serial  = serial_reg;
    assign o_Tx_Active  = active_reg;
    assign o_Tx_Done    = done_reg;
    assign o_Fifo_Count = count_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
`timescale 1ns/1ps
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7E2, CLKS_PER_BIT=4) with a per-instance
// frame monitor that pops expected bytes from a scoreboard queue and checks every line cycle.
module tb_uart_tx_param;

    localparam int CPB = 4;
    localparam int NI  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NI-1:0]       dv;
    logic [NI-1:0][8:0]  tx_byte;
    logic [NI-1:0]       ready, active, serial, done;
    logic [NI-1:0][2:0]  cnt;

    logic [8:0] exp_q [NI][$];
    int done_cnt [NI];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, inst, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [8:0] v, input bit accept);
        dv[i]      = 1'b1;
        tx_byte[i] = v;
        if (accept) exp_q[i].push_back(v);
    endtask

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : g_inst
        localparam int DB  = (gi == 3) ? 7 : 8;
        localparam int PAR = (gi == 1) ? 2 : (gi == 2) ? 1 : (gi == 3) ? 2 : 0;
        localparam int SB  = (gi == 3) ? 2 : 1;
        localparam int NB  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam int FL  = NB * CPB;

        uart_tx_param #(
            .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(4)
        ) u_dut (
            .i_Clock      (clk),
            .reset        (rst),
            .i_Tx_DV      (dv[gi]),
            .i_Tx_Byte    (tx_byte[gi][DB-1:0]),
            .o_Tx_Ready   (ready[gi]),
            .o_Tx_Active  (active[gi]),
            .o_Tx_Serial  (serial[gi]),
            .o_Tx_Done    (done[gi]),
            .o_Fifo_Count (cnt[gi])
        );

        initial done_cnt[gi] = 0;
        always @(posedge clk) if (done[gi] === 1'b1) done_cnt[gi] <= done_cnt[gi] + 1;

        // Frame monitor: starts on a low line, checks each cycle, then the done pulse and chaining
        initial begin : mon
            logic [15:0] bits;
            logic [8:0]  b;
            bit          chain, aborted;
            forever begin
                @(negedge clk);
                if (rst !== 1'b0 || serial[gi] !== 1'b0) continue;
                chain = 1'b1;
                while (chain) begin
                    chain = 1'b0;
                    chk("frame_expected", gi, 32'(exp_q[gi].size() != 0), 32'd1);
                    if (exp_q[gi].size() == 0) break;
                    b = exp_q[gi].pop_front();
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int d = 0; d < DB; d++) bits[1 + d] = b[d];
                    if (PAR == 2) bits[1 + DB] = ^b[DB-1:0];
                    if (PAR == 1) bits[1 + DB] = ~^b[DB-1:0];
                    aborted = 1'b0;
                    for (int c = 0; c < FL; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst !== 1'b0) begin aborted = 1'b1; break; end
                        chk($sformatf("serial_bit%0d", c / CPB), gi, 32'(serial[gi]), 32'(bits[c / CPB]));
                        chk("active_in_frame", gi, 32'(active[gi]), 32'd1);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (rst !== 1'b0) aborted = 1'b1;
                    end
                    if (aborted) begin
                        exp_q[gi].delete();
                        break;
                    end
                    chk("done_pulse", gi, 32'(done[gi]), 32'd1);
                    if (exp_q[gi].size() != 0) begin
                        chk("chain_start_low", gi, 32'(serial[gi]), 32'd0);
                        chk("chain_active", gi, 32'(active[gi]), 32'd1);
                        chain = 1'b1;
                    end else begin
                        chk("idle_high", gi, 32'(serial[gi]), 32'd1);
                        chk("idle_inactive", gi, 32'(active[gi]), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        dv = '0;
        tx_byte = '0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            chk("rst_serial", i, 32'(serial[i]), 32'd1);
            chk("rst_active", i, 32'(active[i]), 32'd0);
            chk("rst_done", i, 32'(done[i]), 32'd0);
            chk("rst_count", i, 32'(cnt[i]), 32'd0);
            chk("rst_ready", i, 32'(ready[i]), 32'd1);
        end
        rst = 1'b0;
        tick();

        // Single frames: 8N1/8E1/8O1 with 0xA5, 7E2 with 0x41
        send(0, 9'h0A5, 1'b1);
        send(1, 9'h0A5, 1'b1);
        send(2, 9'h0A5, 1'b1);
        send(3, 9'h041, 1'b1);
        tick();
        dv = '0;
        chk("latency_still_high", 0, 32'(serial[0]), 32'd1);
        chk("count_after_push", 0, 32'(cnt[0]), 32'd1);
        tick();
        chk("latency_low", 0, 32'(serial[0]), 32'd0);
        chk("latency_active", 0, 32'(active[0]), 32'd1);
        chk("count_after_pop", 0, 32'(cnt[0]), 32'd0);
        repeat (60) tick();
        for (int i = 0; i < NI; i++) begin
            chk("single_done_count", i, 32'(done_cnt[i]), 32'd1);
            chk("single_idle_line", i, 32'(serial[i]), 32'd1);
        end

        // Back-to-back: three writes on consecutive cycles
        send(0, 9'h011, 1'b1);
        tick();
        send(0, 9'h022, 1'b1);
        tick();
        send(0, 9'h033, 1'b1);
        tick();
        dv[0] = 1'b0;
        chk("b2b_count_peak", 0, 32'(cnt[0]), 32'd2);
        repeat (130) tick();
        chk("b2b_done_count", 0, 32'(done_cnt[0]), 32'd4);

        // Overflow: 5 writes during an active frame, the 5th is dropped
        send(0, 9'h05A, 1'b1);
        tick();
        dv[0] = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("ovf_ready_before_5th", 0, 32'(ready[0]), 32'd0);
            send(0, 9'(8'hC1 + i), i < 4);
            tick();
            chk("ovf_count", 0, 32'(cnt[0]), (i < 4) ? 32'(i + 1) : 32'd4);
            chk("ovf_ready", 0, 32'(ready[0]), (i < 3) ? 32'd1 : 32'd0);
        end
        dv[0] = 1'b0;
        repeat (210) tick();
        chk("ovf_done_count", 0, 32'(done_cnt[0]), 32'd9);
        chk("ovf_count_drained", 0, 32'(cnt[0]), 32'd0);

        // Reset during data bit 3 with two bytes queued
        send(0, 9'h077, 1'b1);
        tick();
        send(0, 9'h088, 1'b1);
        tick();
        send(0, 9'h099, 1'b1);
        tick();
        dv[0] = 1'b0;
        repeat (16) tick();
        chk("mid_queued", 0, 32'(cnt[0]), 32'd2);
        chk("mid_bit3", 0, 32'(serial[0]), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_serial", 0, 32'(serial[0]), 32'd1);
        chk("mid_rst_active", 0, 32'(active[0]), 32'd0);
        chk("mid_rst_count", 0, 32'(cnt[0]), 32'd0);
        chk("mid_rst_done", 0, 32'(done[0]), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            chk("post_rst_line", 0, 32'(serial[0]), 32'd1);
            chk("post_rst_active", 0, 32'(active[0]), 32'd0);
        end
        chk("post_rst_done_count", 0, 32'(done_cnt[0]), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
